// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one program-memory port between fetch and debug with a registered command stage and 2-cycle responses.
module pmem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int MEM_BYTES    = 256,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_rsp_valid,
  output logic [31:0]           if_rsp_data,
  output logic                  if_rsp_err,
  input  logic                  dbg_halt,
  input  logic                  dbg_req_valid,
  output logic                  dbg_req_ready,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [31:0]           dbg_wdata,
  input  logic [3:0]            dbg_be,
  output logic                  dbg_rsp_valid,
  output logic [31:0]           dbg_rsp_data,
  output logic                  dbg_rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_rdata,
  output logic                  mem_we,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MEM_BYTES - 4);
  logic [SW-1:0] starve_q, starve_d;
  logic force_if, if_wait, rd_ok;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0] rd_data;
  logic cmd_valid_q, cmd_valid_d, cmd_src_q, cmd_src_d, cmd_we_q, cmd_we_d, cmd_err_q, cmd_err_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [31:0] cmd_wdata_q, cmd_wdata_d;
  logic [3:0] cmd_be_q, cmd_be_d;
  logic if_rsp_valid_q, if_rsp_valid_d, if_rsp_err_q, if_rsp_err_d;
  logic dbg_rsp_valid_q, dbg_rsp_valid_d, dbg_rsp_err_q, dbg_rsp_err_d;
  logic [31:0] if_rsp_data_q, if_rsp_data_d, dbg_rsp_data_q, dbg_rsp_data_d;
  assign force_if      = starve_q == SW'(STARVE_LIMIT);
  assign dbg_req_ready = dbg_req_valid & ~(force_if & if_req_valid & ~dbg_halt);
  assign if_req_ready  = if_req_valid & ~dbg_halt & (~dbg_req_valid | force_if);
  always_comb begin
    if_wait         = if_req_valid & ~dbg_halt;
    starve_d        = (if_req_ready | ~if_wait) ? '0 :
                      (dbg_req_ready & ~force_if) ? starve_q + 1'b1 : starve_q;
    req_addr        = dbg_req_ready ? dbg_addr : if_addr;
    cmd_valid_d     = if_req_ready | dbg_req_ready;
    cmd_src_d       = dbg_req_ready;
    cmd_we_d        = dbg_req_ready & dbg_we;
    cmd_addr_d      = cmd_valid_d ? req_addr : cmd_addr_q;
    cmd_wdata_d     = dbg_req_ready ? dbg_wdata : '0;
    cmd_be_d        = dbg_req_ready ? dbg_be : 4'hf;
    cmd_err_d       = cmd_valid_d & ((req_addr[1:0] != 2'b00) | (req_addr > LAST));
    rd_ok           = cmd_valid_q & ~cmd_we_q & ~cmd_err_q;
    rd_data         = rd_ok ? mem_rdata : '0;
    if_rsp_valid_d  = cmd_valid_q & ~cmd_src_q;
    if_rsp_err_d    = if_rsp_valid_d & cmd_err_q;
    if_rsp_data_d   = if_rsp_valid_d ? rd_data : '0;
    dbg_rsp_valid_d = cmd_valid_q & cmd_src_q;
    dbg_rsp_err_d   = dbg_rsp_valid_d & cmd_err_q;
    dbg_rsp_data_d  = dbg_rsp_valid_d ? rd_data : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q        <= '0;
      cmd_valid_q     <= 1'b0;
      cmd_src_q       <= 1'b0;
      cmd_we_q        <= 1'b0;
      cmd_err_q       <= 1'b0;
      cmd_addr_q      <= '0;
      cmd_wdata_q     <= '0;
      cmd_be_q        <= '0;
      if_rsp_valid_q  <= 1'b0;
      if_rsp_err_q    <= 1'b0;
      if_rsp_data_q   <= '0;
      dbg_rsp_valid_q <= 1'b0;
      dbg_rsp_err_q   <= 1'b0;
      dbg_rsp_data_q  <= '0;
    end else begin
      starve_q        <= starve_d;
      cmd_valid_q     <= cmd_valid_d;
      cmd_src_q       <= cmd_src_d;
      cmd_we_q        <= cmd_we_d;
      cmd_err_q       <= cmd_err_d;
      cmd_addr_q      <= cmd_addr_d;
      cmd_wdata_q     <= cmd_wdata_d;
      cmd_be_q        <= cmd_be_d;
      if_rsp_valid_q  <= if_rsp_valid_d;
      if_rsp_err_q    <= if_rsp_err_d;
      if_rsp_data_q   <= if_rsp_data_d;
      dbg_rsp_valid_q <= dbg_rsp_valid_d;
      dbg_rsp_err_q   <= dbg_rsp_err_d;
      dbg_rsp_data_q  <= dbg_rsp_data_d;
    end
  end
  assign mem_addr      = cmd_addr_q;
  assign mem_we        = cmd_valid_q & cmd_we_q & ~cmd_err_q;
  assign mem_wdata     = cmd_wdata_q;
  assign mem_be        = cmd_valid_q ? cmd_be_q : 4'h0;
  assign if_rsp_valid  = if_rsp_valid_q;
  assign if_rsp_err    = if_rsp_err_q;
  assign if_rsp_data   = if_rsp_data_q;
  assign dbg_rsp_valid = dbg_rsp_valid_q;
  assign dbg_rsp_err   = dbg_rsp_err_q;
  assign dbg_rsp_data  = dbg_rsp_data_q;
endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: directed stimulus with a queue scoreboard and an independent response monitor.
module tb_pmem_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err;
  logic [31:0] if_addr, if_rsp_data;
  logic dbg_halt, dbg_req_valid, dbg_req_ready, dbg_we, dbg_rsp_valid, dbg_rsp_err;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rsp_data;
  logic [3:0] dbg_be, mem_be;
  logic [31:0] mem_addr, mem_rdata, mem_wdata;
  logic mem_we;
  pmem_arbiter #(.ADDR_WIDTH(32), .MEM_BYTES(256), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
    .dbg_halt(dbg_halt), .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_be(dbg_be),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_data(dbg_rsp_data), .dbg_rsp_err(dbg_rsp_err),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_be(mem_be)
  );
  logic [7:0] mem [256];
  assign mem_rdata = {mem[8'(mem_addr[7:0] + 8'd3)], mem[8'(mem_addr[7:0] + 8'd2)],
                      mem[8'(mem_addr[7:0] + 8'd1)], mem[mem_addr[7:0]]};
  always @(posedge clk)
    if (mem_we)
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) mem[8'(mem_addr[7:0] + 8'(i))] = mem_wdata[8*i +: 8];
  typedef struct {logic [31:0] d; logic e; int due;} ent_t;
  ent_t qi[$], qd[$];
  int total = 0, bad = 0, cyc = 0, we_cnt = 0;
  logic [31:0] ei_d, ed_d;
  logic ei_e, ed_e, push_en;
  byte g;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    ent_t x;
    if (mem_we) we_cnt++;
    if (if_rsp_valid) begin
      if (qi.size() == 0) chk("if_unexpected_rsp", 32'd1, 32'd0);
      else begin
        x = qi.pop_front();
        chk("if_data", if_rsp_data, x.d);
        chk("if_err", {31'd0, if_rsp_err}, {31'd0, x.e});
        chk("if_latency", cyc, x.due);
      end
    end
    if (dbg_rsp_valid) begin
      if (qd.size() == 0) chk("dbg_unexpected_rsp", 32'd1, 32'd0);
      else begin
        x = qd.pop_front();
        chk("dbg_data", dbg_rsp_data, x.d);
        chk("dbg_err", {31'd0, dbg_rsp_err}, {31'd0, x.e});
        chk("dbg_latency", cyc, x.due);
      end
    end
  end
  task automatic step();
    @(negedge clk);
    g = if_req_ready ? "F" : dbg_req_ready ? "D" : "-";
    if (if_req_ready && push_en) qi.push_back('{ei_d, ei_e, cyc + 2});
    if (dbg_req_ready && push_en) qd.push_back('{ed_d, ed_e, cyc + 2});
    @(posedge clk);
    #1;
  endtask
  task automatic put_word(input int a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem[a + i] = w[8*i +: 8];
  endtask
  initial begin
    string pat;
    int n_rdy, we0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    put_word(32'h00, 32'h20000513);
    put_word(32'h04, 32'h00400593);
    put_word(32'h08, 32'h20400693);
    put_word(32'h10, 32'h00B76463);
    put_word(32'h20, 32'h11111111);
    put_word(32'h24, 32'h22222222);
    {if_req_valid, dbg_halt, dbg_req_valid, dbg_we} = '0;
    {if_addr, dbg_addr, dbg_wdata, dbg_be} = '0;
    {ei_d, ed_d, ei_e, ed_e} = '0;
    push_en = 1'b1;
    #1;
    chk("rst_if_rsp_valid", {31'd0, if_rsp_valid}, 32'd0);
    chk("rst_dbg_rsp_valid", {31'd0, dbg_rsp_valid}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    if_req_valid = 1'b1;
    #1;
    chk("rst_ready_comb", {31'd0, if_req_ready}, 32'd1);
    if_req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    // back-to-back fetches
    if_req_valid = 1'b1;
    if_addr = 32'h00; ei_d = 32'h20000513; step(); chk("t1_grant0", 32'(g), 32'("F"));
    if_addr = 32'h04; ei_d = 32'h00400593; step(); chk("t1_grant1", 32'(g), 32'("F"));
    if_addr = 32'h08; ei_d = 32'h20400693; step(); chk("t1_grant2", 32'(g), 32'("F"));
    if_req_valid = 1'b0;
    repeat (3) step();
    // partial debug write, then read-back
    dbg_req_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h10; dbg_wdata = 32'hDEADBEEF; dbg_be = 4'b0011;
    ed_d = 32'h0; ed_e = 1'b0; step(); chk("t2_wr_grant", 32'(g), 32'("D"));
    dbg_we = 1'b0; ed_d = 32'h00B7BEEF; step(); chk("t2_rd_grant", 32'(g), 32'("D"));
    dbg_req_valid = 1'b0;
    repeat (3) step();
    // errors never touch memory
    we0 = we_cnt;
    if_req_valid = 1'b1; if_addr = 32'h02; ei_d = 32'h0; ei_e = 1'b1;
    dbg_req_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 32'hFE; ed_d = 32'h0; ed_e = 1'b1;
    step(); chk("t3_grant_dbg", 32'(g), 32'("D"));
    dbg_we = 1'b1; dbg_addr = 32'h13; dbg_be = 4'hF; step(); chk("t3_grant_dbgw", 32'(g), 32'("D"));
    dbg_req_valid = 1'b0; step(); chk("t3_grant_if", 32'(g), 32'("F"));
    if_req_valid = 1'b0; dbg_we = 1'b0;
    dbg_req_valid = 1'b1; dbg_addr = 32'h100; step();
    dbg_req_valid = 1'b0;
    repeat (3) step();
    chk("t3_no_mem_we", 32'(we_cnt), 32'(we0));
    // starvation limit
    ei_e = 1'b0; ed_e = 1'b0;
    if_req_valid = 1'b1; if_addr = 32'h24; ei_d = 32'h22222222;
    dbg_req_valid = 1'b1; dbg_addr = 32'h20; ed_d = 32'h11111111;
    pat = "DDDDFDDDDFDD";
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("t4_grant%0d", i), 32'(g), 32'(pat[i]));
    end
    {if_req_valid, dbg_req_valid} = '0;
    repeat (3) step();
    // halt: accepted fetch still completes, then no grants until release
    if_req_valid = 1'b1; if_addr = 32'h00; ei_d = 32'h20000513;
    step(); chk("t5_pre_halt", 32'(g), 32'("F"));
    dbg_halt = 1'b1; n_rdy = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (g != "-") n_rdy++;
    end
    chk("t5_halt_grants", 32'(n_rdy), 32'd0);
    dbg_halt = 1'b0;
    step(); chk("t5_release_grant", 32'(g), 32'("F"));
    if_req_valid = 1'b0;
    repeat (3) step();
    // reset with a fetch in the access stage
    push_en = 1'b0;
    if_req_valid = 1'b1; if_addr = 32'h08;
    step(); chk("t6_grant", 32'(g), 32'("F"));
    if_req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_mem_addr", mem_addr, 32'd0);
    chk("t6_mem_be", {28'd0, mem_be}, 32'd0);
    chk("t6_mem_we", {31'd0, mem_we}, 32'd0);
    chk("t6_if_rsp_valid", {31'd0, if_rsp_valid}, 32'd0);
    chk("t6_if_rsp_data", if_rsp_data, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("t6_if_rsp_after", {31'd0, if_rsp_valid}, 32'd0);
    repeat (3) step();
    push_en = 1'b1;
    if_req_valid = 1'b1; if_addr = 32'h04; ei_d = 32'h00400593;
    step(); chk("t6_post_grant", 32'(g), 32'("F"));
    if_req_valid = 1'b0;
    repeat (4) step();
    chk("end_if_queue", 32'(qi.size()), 32'd0);
    chk("end_dbg_queue", 32'(qd.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pmem_arbiter.md
# pmem_arbiter

Two-port arbiter and access sequencer for the byte-addressed, little-endian program memory. It lets the instruction-fetch path and a debug/loader port share the single memory port, drives every memory access through a registered command stage, and returns registered responses with a fixed 2-cycle latency. Misaligned or out-of-range accesses are rejected with an error response and never reach the memory.

## Interface
- ADDR_WIDTH, 32, width of all address ports
- MEM_BYTES, 256, memory size in bytes; a legal word address satisfies addr + 3 < MEM_BYTES
- STARVE_LIMIT, 4, maximum consecutive debug grants while fetch is waiting; must be ≥ 1

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req_valid  in  1  fetch read request
- if_req_ready  out  1  fetch request accepted this cycle
- if_addr  in  ADDR_WIDTH  fetch byte address
- if_rsp_valid  out  1  fetch response valid, one-cycle pulse
- if_rsp_data  out  32  fetched word
- if_rsp_err  out  1  fetch address misaligned or out of range
- dbg_halt  in  1  blocks all fetch grants while high
- dbg_req_valid  in  1  debug request
- dbg_req_ready  out  1  debug request accepted this cycle
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  ADDR_WIDTH  debug byte address
- dbg_wdata  in  32  write data
- dbg_be  in  4  byte enables; bit i enables byte addr+i
- dbg_rsp_valid  out  1  debug response valid, one-cycle pulse; issued for reads and writes
- dbg_rsp_data  out  32  read data; 0 for writes and errors
- dbg_rsp_err  out  1  debug address misaligned or out of range
- mem_addr  out  ADDR_WIDTH  memory byte address
- mem_rdata  in  32  combinational read data for mem_addr
- mem_we  out  1  write strobe; memory commits on the rising edge ending the cycle
- mem_wdata  out  32  write data
- mem_be  out  4  byte enables

## Operation
- Grant logic is combinational from the valids and registered state:
  - force_if = (starve_cnt == STARVE_LIMIT)
  - dbg_req_ready = dbg_req_valid & ~(force_if & if_req_valid & ~dbg_halt)
  - if_req_ready = if_req_valid & ~dbg_halt & (~dbg_req_valid | force_if)
- At most one grant per cycle. Debug has priority unless force_if is set.
- starve_cnt, width clog2(STARVE_LIMIT+1):
  - increments on a debug grant while if_req_valid & ~dbg_halt
  - clears on a fetch grant, or in any cycle where fetch is not waiting
  - saturates at STARVE_LIMIT
- Command stage: on a grant, cmd_valid, cmd_src, cmd_we, cmd_addr, cmd_wdata, cmd_be and cmd_err are registered. cmd_err = (addr[1:0] != 0) | (addr > MEM_BYTES-4), compared at full ADDR_WIDTH. Without a grant, cmd_valid is 0.
- Access stage (cycle in which cmd_valid = 1):
  - mem_addr = cmd_addr
  - mem_we = cmd_valid & cmd_we & ~cmd_err
  - mem_wdata = cmd_wdata
  - mem_be = cmd_be
  - When cmd_valid = 0, mem_we and mem_be are 0.
- Response stage: at the edge ending the access cycle, the response registers of cmd_src load valid = 1, err = cmd_err, and data = (read & ~err) ? mem_rdata : 0. The other source's rsp_valid is 0.
- Fetch requests ignore dbg_we, dbg_be and dbg_wdata; a fetch is always a read.
- There is no response back-pressure. Requesters must sample the response in the cycle rsp_valid is high.

## Timing
- Reset (asynchronous, takes effect immediately): cmd_valid = 0, both rsp_valid = 0, rsp_data = 0, rsp_err = 0, starve_cnt = 0, mem_we = 0, mem_be = 0, mem_addr = 0. In-flight requests are dropped and produce no response. Ready outputs follow the combinational equations even during reset.
- Latency: request handshake at edge E0 → access in cycle E0..E1 → rsp_valid high in cycle E1..E2.
- Throughput: one access per cycle, fully pipelined, with any interleaving of sources.
- A debug write to address A at handshake E0, followed by a fetch of A at handshake E0+1, returns the new data.
- When dbg_halt rises, fetch commands already accepted still complete and respond.

## Test plan
- Reset, then fetch 0x00, 0x04, 0x08 back-to-back with memory holding 0x20000513, 0x00400593, 0x20400693 → if_rsp_valid high for 3 consecutive cycles starting 2 cycles after the first handshake, carrying those words in order, err = 0.
- Debug write 0xDEADBEEF with be = 4'b0011 to 0x10 (old word 0x00B76463), then debug read 0x10 → read returns 0x0000BEEF merged with old upper bytes (0x00B7BEEF); both dbg_rsp_valid pulses occur, err = 0.
- Fetch 0x02 and debug read 0xFE with MEM_BYTES = 256 → both respond with err = 1 and data = 0; mem_we stays 0 throughout.
- Hold dbg_req_valid and if_req_valid high for 12 cycles with STARVE_LIMIT = 4 → grant pattern D D D D F D D D D F …; the fetch waits at most 5 cycles.
- dbg_halt = 1 with if_req_valid held high for 10 cycles → if_req_ready stays 0, no if_rsp_valid. After dbg_halt falls, the first grant occurs the same cycle.
- Assert rst for one cycle while one fetch is in the access stage → no if_rsp_valid follows, all outputs read their reset values, and the next fetch after reset completes with 2-cycle latency.
